cover_toggle_report_sched: RTL and testbench
============================================

// Module: cover_toggle_report_sched
// PURPOSE
//  Scheduler between a toggle-coverage hit vector and one coverage reporting port.
//  - Captures per-point hit strobes every cycle and reports each point exactly once,
//    one report per cycle, over a valid/ready handshake.
//  - Replaces N per-bit report calls per cycle with one serialized channel that
//    downstream reporting logic can throttle.
//  - Sits between the per-module toggle hit vector and the global coverage collector.
// PARAMETERS
//  N            15     number of toggle points handled by this instance
//  COVER_INDEX  0      global index of point 0; point i reports COVER_INDEX+i
//  IDX_W        64     width of reported global index
//  CNT_W        4      covered-count width; must equal $clog2(N+1)
// PORTS
//  clock          in   1      sole clock, rising edge
//  reset          in   1      synchronous, active-high; clears all state
//  valid          in   N      per-point hit strobes, sampled every clock edge
//  out_valid      out  1      report available
//  out_ready      in   1      collector accepts report when out_valid & out_ready
//  out_index      out  IDX_W  global point index = COVER_INDEX + sel
//  covered_count  out  CNT_W  number of reports accepted since reset
//  all_covered    out  1      covered_count == N
// BEHAVIOUR
//  Per-point state:
//  - pending[i]: hit captured, not yet issued.
//  - issued[i]: loaded into the output register (sticky until reset).
//  - claimed[i] = pending[i] | issued[i].
//  Capture:
//  - At each edge with reset low: pending[i] <= pending[i] | (valid[i] & ~claimed[i]).
//  - valid is ignored while reset is high.
//  - A point is never reported twice; repeated or held hits are absorbed.
//  Output register load (load = ~out_valid | out_ready):
//  - When load and pending != 0: select sel = first pending index at/after ptr,
//    searching upward and wrapping N-1 -> 0.
//  - Then: out_valid <= 1, out_index <= COVER_INDEX + sel, pending[sel] <= 0,
//    issued[sel] <= 1, ptr <= (sel == N-1) ? 0 : sel+1.
//  - When load and pending == 0: out_valid <= 0; out_index holds.
//  - Selection uses registered pending only. A hit captured at edge e0 is loadable
//    at edge e1, so out_valid is high in the cycle after e1 (2-edge latency).
//  - A hit on point j in the same cycle j is loaded is absorbed: j is already claimed.
//  Handshake:
//  - While out_valid & ~out_ready: out_valid and out_index held stable; no load.
//  - out_valid never drops without acceptance.
//  - Throughput 1 report/cycle with out_ready held high and pending nonempty.
//  Counting:
//  - covered_count increments by 1 on each out_valid & out_ready, saturating at N
//    (cannot exceed N by construction).
//  - all_covered is combinational from covered_count.
//  Reset (any cycle, including mid-stall):
//  - Next cycle: out_valid=0, out_index=0, covered_count=0, all_covered=0,
//    pending=0, issued=0, ptr=0.
//  - An in-flight unaccepted report is dropped; every point becomes reportable again.
//  - Boundary: ptr == N-1 and only point N-1 pending -> sel = N-1, ptr wraps to 0.
// TESTING
//  1 reset; valid=15'h0001 for 1 cycle; out_ready=1 -> out_valid high 2 edges later,
//    for 1 cycle, out_index=COVER_INDEX+0; then covered_count=1.
//  2 valid=15'h7FFF for 1 cycle; out_ready=1 -> 15 back-to-back reports with indices
//    +0..+14 in order; after last accept covered_count=15, all_covered=1.
//  3 valid[6] hit; out_ready=0 for 5 cycles -> out_valid=1, out_index=+6 stable all
//    5 cycles; covered_count=0; out_ready=1 -> accepted once, covered_count=1.
//  4 valid[3] held high 10 cycles, out_ready=1 -> exactly one report (+3);
//    covered_count=1.
//  5 valid bits {1,5,12} in one cycle; valid[3] hit while +5 is output -> report
//    order +1,+5,+12,+3 (ptr=6 after +5, wraps after +12).
//  6 stall with +2 in flight, assert reset 1 cycle -> next cycle all outputs 0;
//    re-hit point 2 -> reported again as +2.

Source files
------------

// File: rtl/cover_toggle_report_sched.sv
// Serialises a per-point toggle-coverage hit vector into one valid/ready report stream.
// Each point is reported at most once between resets, and the count of accepted reports is tracked.
module cover_toggle_report_sched #(
  parameter int               N           = 15,
  parameter int               IDX_W       = 64,
  parameter logic [IDX_W-1:0] COVER_INDEX = '0,
  parameter int               CNT_W       = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [N-1:0]     valid,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_index,
  output logic [CNT_W-1:0] covered_count,
  output logic             all_covered
);

  localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]     r_pending;
  logic [N-1:0]     r_issued;
  logic [PTR_W-1:0] r_ptr;
  logic             r_out_valid;
  logic [IDX_W-1:0] r_out_index;
  logic [CNT_W-1:0] r_count;

  logic             w_load;
  logic             w_found;
  logic [PTR_W-1:0] w_sel;
  logic [N-1:0]     w_clr;
  logic [N-1:0]     w_claimed;
  logic             w_accept;

  assign w_load    = ~r_out_valid | out_ready;
  assign w_accept  = r_out_valid & out_ready;
  assign w_claimed = r_pending | r_issued;

  // Round-robin search: first pending point at or after r_ptr, wrapping N-1 -> 0.
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    for (int unsigned k = 0; k < N; k++) begin
      int unsigned idx;
      idx = int'(r_ptr) + k;
      if (idx >= N) idx = idx - N;
      if (!w_found && r_pending[idx]) begin
        w_found = 1'b1;
        w_sel   = PTR_W'(idx);
      end
    end
  end

  always_comb begin
    w_clr = '0;
    if (w_load && w_found) w_clr[w_sel] = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_pending   <= '0;
      r_issued    <= '0;
      r_ptr       <= '0;
      r_out_valid <= 1'b0;
      r_out_index <= '0;
      r_count     <= '0;
    end else begin
      // Hits on already-claimed points (including the one loading now) are absorbed.
      r_pending <= (r_pending & ~w_clr) | (valid & ~w_claimed);
      r_issued  <= r_issued | w_clr;
      if (w_load) begin
        r_out_valid <= w_found;
        if (w_found) begin
          r_out_index <= COVER_INDEX + IDX_W'(w_sel);
          r_ptr       <= (int'(w_sel) == N - 1) ? '0 : w_sel + 1'b1;
        end
      end
      if (w_accept && (int'(r_count) < N)) r_count <= r_count + 1'b1;
    end
  end

  assign out_valid     = r_out_valid;
  assign out_index     = r_out_index;
  assign covered_count = r_count;
  assign all_covered   = (int'(r_count) == N);

endmodule

// File: tb/tb_cover_toggle_report_sched.sv
// Directed bench for cover_toggle_report_sched: ordering, stalls, absorption, wrap and reset.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_cover_toggle_report_sched;

  localparam int N = 15;

  logic          clock = 1'b0;
  logic          reset;
  logic [N-1:0]  valid;
  logic          out_valid;
  logic          out_ready;
  logic [63:0]   out_index;
  logic [3:0]    covered_count;
  logic          all_covered;

  int n_pass  = 0;
  int n_total = 0;

  cover_toggle_report_sched #(
    .N          (15),
    .IDX_W      (64),
    .COVER_INDEX(64'd0),
    .CNT_W      (4)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .valid        (valid),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_index    (out_index),
    .covered_count(covered_count),
    .all_covered  (all_covered)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [63:0] idx, input int cnt);
    chk({tag, ".valid"}, 64'(out_valid), 64'(v));
    if (v) chk({tag, ".index"}, out_index, idx);
    chk({tag, ".count"}, 64'(covered_count), 64'(cnt));
  endtask

  initial begin
    int reports;
    reset     = 1'b1;
    valid     = '0;
    out_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    chk("rst.valid", 64'(out_valid), 64'd0);
    chk("rst.index", out_index, 64'd0);
    chk("rst.count", 64'(covered_count), 64'd0);
    chk("rst.all", 64'(all_covered), 64'd0);

    // 1: single hit, two-edge latency
    out_ready = 1'b1;
    valid = 15'h0001;
    tick();
    valid = '0;
    chk_out("t1.e0", 1'b0, 64'd0, 0);
    tick();
    chk_out("t1.e1", 1'b1, 64'd0, 0);
    tick();
    chk_out("t1.e2", 1'b0, 64'd0, 1);

    // 2: all points, back-to-back in order, then all_covered
    do_reset();
    valid = 15'h7FFF;
    tick();
    valid = '0;
    for (int k = 0; k < N; k++) begin
      tick();
      chk_out($sformatf("t2.r%0d", k), 1'b1, 64'(k), k);
    end
    tick();
    chk_out("t2.end", 1'b0, 64'd0, 15);
    chk("t2.all", 64'(all_covered), 64'd1);

    // 3: stall holds output stable
    do_reset();
    out_ready = 1'b0;
    valid = 15'h0040;
    tick();
    valid = '0;
    tick();
    chk_out("t3.load", 1'b1, 64'd6, 0);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk_out($sformatf("t3.stall%0d", k), 1'b1, 64'd6, 0);
    end
    out_ready = 1'b1;
    tick();
    chk_out("t3.acc", 1'b0, 64'd0, 1);
    tick();
    chk_out("t3.after", 1'b0, 64'd0, 1);

    // 4: held hit absorbed into a single report
    do_reset();
    valid = 15'h0008;
    reports = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (out_valid) begin
        reports++;
        chk("t4.index", out_index, 64'd3);
      end
    end
    valid = '0;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (out_valid) reports++;
    end
    chk("t4.reports", 64'(reports), 64'd1);
    chk("t4.count", 64'(covered_count), 64'd1);

    // 5: round-robin order with wrap
    do_reset();
    valid = 15'h1022;
    tick();
    valid = '0;
    tick();
    chk_out("t5.r1", 1'b1, 64'd1, 0);
    tick();
    chk_out("t5.r5", 1'b1, 64'd5, 1);
    valid = 15'h0008;
    tick();
    valid = '0;
    chk_out("t5.r12", 1'b1, 64'd12, 2);
    tick();
    chk_out("t5.r3", 1'b1, 64'd3, 3);
    tick();
    chk_out("t5.end", 1'b0, 64'd0, 4);

    // 7: pointer at N-1 with only N-1 pending, then wrap to 0
    do_reset();
    valid = 15'h2000;
    tick();
    valid = '0;
    tick();
    chk_out("tw.r13", 1'b1, 64'd13, 0);
    valid = 15'h4000;
    tick();
    valid = '0;
    chk_out("tw.gap", 1'b0, 64'd0, 1);
    tick();
    chk_out("tw.r14", 1'b1, 64'd14, 1);
    valid = 15'h0001;
    tick();
    valid = '0;
    chk_out("tw.gap2", 1'b0, 64'd0, 2);
    tick();
    chk_out("tw.r0", 1'b1, 64'd0, 2);
    tick();
    chk_out("tw.end", 1'b0, 64'd0, 3);

    // 6: reset mid-stall drops in-flight report, point reportable again
    do_reset();
    out_ready = 1'b0;
    valid = 15'h0004;
    tick();
    valid = '0;
    tick();
    chk_out("t6.load", 1'b1, 64'd2, 0);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t6.rst.valid", 64'(out_valid), 64'd0);
    chk("t6.rst.index", out_index, 64'd0);
    chk("t6.rst.count", 64'(covered_count), 64'd0);
    chk("t6.rst.all", 64'(all_covered), 64'd0);
    valid = 15'h0004;
    tick();
    valid = '0;
    tick();
    chk_out("t6.rehit", 1'b1, 64'd2, 0);
    out_ready = 1'b1;
    tick();
    chk_out("t6.acc", 1'b0, 64'd0, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
